garbage_rise: RTL and testbench
===============================

GARBAGE_RISE -- requirements
Module: garbage_rise

Interface
REQ-001 Parameter GARBAGE_TYPE, default 7: type code written into every type field of an inserted garbage row.
REQ-002 Parameter LFSR_SEED, default 8'hA5: LFSR reset value; any nonzero value is legal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  insertion request present.
REQ-006 req_ready  output  1  block idle and able to accept a request.
REQ-007 req_count  input  3  number of garbage rows to insert, 1..4.
REQ-008 hole_col  input  4  column left empty in each garbage row (used only without GARBAGE_LFSR_EN).
REQ-009 board_in  input  `BOARD_SIZE  board captured on accept; same row/fill/type layout as all other board ports.
REQ-010 board_out  output  `BOARD_SIZE  working board; final result is valid when done is high.
REQ-011 done  output  1  one-cycle pulse; insertion complete.
REQ-012 top_out  output  1  sticky flag; an occupied row was pushed past row `BOARD_H-1.

Function
REQ-013 Row 0 is the bottom row and row `BOARD_H-1 is the top row; fill bit 1 = occupied cell; empty row = fill all zeros, type all zeros.
REQ-014 FSM states are IDLE, RISE and DONE; req_ready = 1 only in IDLE.
REQ-015 Accept occurs when req_valid && req_ready && req_count in 1..4; on accept, board_out <= board_in, remaining <= req_count, top_out <= 0, hole latched, state -> RISE.
REQ-016 req_valid with req_count = 0 or 5..7 is not accepted; the FSM stays in IDLE and all outputs hold.
REQ-017 Each RISE cycle shifts the board up one row: new row k = old row k-1 for k = 1..`BOARD_H-1; new row 0 = garbage row.
REQ-018 Garbage row: all fill bits 1 except the bit at the hole column, which is 0; every type field = GARBAGE_TYPE.
REQ-019 In any RISE cycle where the old top row fill is nonzero, top_out <= 1; top_out stays 1 until the next accept.
REQ-020 remaining decrements once per RISE cycle; when remaining reaches 0, state -> DONE.
REQ-021 DONE lasts exactly one cycle with done = 1, then the FSM returns to IDLE; board_out holds its value in IDLE.
REQ-022 Latency: req_count = N gives done exactly N+1 cycles after the accept edge.
REQ-023 Hole columns >= `BOARD_W are reduced modulo `BOARD_W.
REQ-024 req_valid while busy is ignored; the requester holds req_valid until it sees req_ready.

Reset
REQ-025 When rst_n = 0 at a clock edge: state = IDLE, board_out = all zeros, remaining = 0, done = 0, top_out = 0, LFSR = LFSR_SEED.
REQ-026 Reset asserted mid-insertion aborts the operation on that edge; done is not pulsed and the partial board is discarded.

Configuration
REQ-027 Macro GARBAGE_LFSR_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances once per RISE cycle; each row's hole = LFSR value mod `BOARD_W; hole_col is ignored.
REQ-028 Macro GARBAGE_LFSR_EN undefined: no LFSR is built; every inserted row uses hole_col latched at accept.

Verification
REQ-029 Empty board, req_count = 2, hole_col = 3, macro off -> rows 0-1 have fill = all ones except bit 3 and type = 7; done at accept+3 cycles; top_out = 0.
REQ-030 Board with only row 19 occupied, req_count = 1 -> top_out = 1 at done; old row 18 is in row 19; row 0 is garbage.
REQ-031 req_count = 4 with a second req_valid pulse issued mid-operation -> the second request is ignored; exactly 4 rows are inserted; req_ready rises the cycle after done.
REQ-032 rst_n low in the 2nd RISE cycle of a 3-row insertion -> next cycle board_out = 0, no done pulse, req_ready = 1.
REQ-033 req_count = 0 with req_valid held 5 cycles -> no accept; board_out unchanged; done never asserts.
REQ-034 Macro on, seed A5, req_count = 4 -> hole sequence matches the golden LFSR model mod `BOARD_W; each garbage row has exactly one zero fill bit.

Source files
------------

// File: rtl/garbage_rise.sv
// Garbage-row insertion: pushes the board up N rows, filling the bottom with holed rows.
// Define GARBAGE_LFSR_EN to pick each row's hole from an 8-bit LFSR instead of hole_col.
`ifndef BOARD_W
`define BOARD_W 10
`endif
`ifndef BOARD_H
`define BOARD_H 20
`endif
`ifndef BOARD_TW
`define BOARD_TW 3
`endif
`ifndef BOARD_SIZE
`define BOARD_SIZE (`BOARD_H * `BOARD_W * (1 + `BOARD_TW))
`endif

module garbage_rise #(
  parameter int          GARBAGE_TYPE = 7,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_count,
  input  logic [3:0]             hole_col,
  input  logic [`BOARD_SIZE-1:0] board_in,
  output logic [`BOARD_SIZE-1:0] board_out,
  output logic                   done,
  output logic                   top_out
);
  localparam int W   = `BOARD_W;
  localparam int H   = `BOARD_H;
  localparam int TW  = `BOARD_TW;
  localparam int BS  = `BOARD_SIZE;
  localparam int ROW = W * (1 + TW);
  localparam logic [TW-1:0] GTYPE = GARBAGE_TYPE[TW-1:0];

  typedef enum logic [1:0] {IDLE, RISE, DONE} state_t;

  state_t          state_q, state_d;
  logic [BS-1:0]   board_d;
  logic [2:0]      rem_q, rem_d;
  logic            top_d;
  logic            accept;
  logic [3:0]      hole;
  logic [W-1:0]    g_fill;
  logic [ROW-1:0]  g_row;
  logic [W-1:0]    top_fill;

`ifdef GARBAGE_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;
  logic       unused_hole_col;
  assign unused_hole_col = ^hole_col;
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign hole    = 4'(lfsr_q % 8'(W));
`else
  logic [3:0] hole_q, hole_d;
  assign hole = hole_q;
`endif

  assign accept = req_valid && (state_q == IDLE) &&
                  (req_count != 3'd0) && (req_count <= 3'd4);
  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign top_fill  = board_out[(H-1)*ROW +: W];

  always_comb begin
    g_fill       = '1;
    g_fill[hole] = 1'b0;
  end

  assign g_row = {{W{GTYPE}}, g_fill};

  always_comb begin
    state_d = state_q;
    board_d = board_out;
    rem_d   = rem_q;
    top_d   = top_out;
`ifdef GARBAGE_LFSR_EN
    lfsr_d  = lfsr_q;
`else
    hole_d  = hole_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RISE;
          board_d = board_in;
          rem_d   = req_count;
          top_d   = 1'b0;
`ifndef GARBAGE_LFSR_EN
          hole_d  = hole_col % 4'(W);
`endif
        end
      end
      RISE: begin
        // Old top row falls off; flag it if anything was in it.
        board_d = {board_out[BS-ROW-1:0], g_row};
        rem_d   = rem_q - 3'd1;
        if (|top_fill) top_d = 1'b1;
`ifdef GARBAGE_LFSR_EN
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
`endif
        if (rem_q == 3'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      board_out <= '0;
      rem_q     <= '0;
      top_out   <= 1'b0;
`ifdef GARBAGE_LFSR_EN
      lfsr_q    <= LFSR_SEED;
`else
      hole_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      board_out <= board_d;
      rem_q     <= rem_d;
      top_out   <= top_d;
`ifdef GARBAGE_LFSR_EN
      lfsr_q    <= lfsr_d;
`else
      hole_q    <= hole_d;
`endif
    end
  end

endmodule

// File: tb/tb_garbage_rise.sv
// Directed bench for garbage_rise: insertion, overflow, busy-ignore, reset abort, bad counts.
// Hole expectations follow hole_col, or the golden LFSR when GARBAGE_LFSR_EN is set.
`ifndef BOARD_W
`define BOARD_W 10
`endif
`ifndef BOARD_H
`define BOARD_H 20
`endif
`ifndef BOARD_TW
`define BOARD_TW 3
`endif
`ifndef BOARD_SIZE
`define BOARD_SIZE (`BOARD_H * `BOARD_W * (1 + `BOARD_TW))
`endif

module tb_garbage_rise;
  localparam int W   = `BOARD_W;
  localparam int H   = `BOARD_H;
  localparam int BS  = `BOARD_SIZE;
  localparam int ROW = BS / H;

  typedef logic [BS-1:0]  board_t;
  typedef logic [ROW-1:0] row_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_count = '0;
  logic [3:0] hole_col = '0;
  board_t     board_in = '0;
  board_t     board_out;
  logic       done;
  logic       top_out;

  int         nvec = 0;
  int         nmis = 0;
  logic [7:0] lfsr_m = 8'hA5;
  board_t     exp_b;
  logic [3:0] h [4];

  garbage_rise dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_count (req_count),
    .hole_col  (hole_col),
    .board_in  (board_in),
    .board_out (board_out),
    .done      (done),
    .top_out   (top_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input board_t obs, input board_t exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic row_t mk_row(input logic [W-1:0] fill, input logic [2:0] t);
    return {{W{t}}, fill};
  endfunction

  function automatic row_t garb(input logic [3:0] hc);
    logic [W-1:0] f;
    f = '1;
    f[hc] = 1'b0;
    return mk_row(f, 3'd7);
  endfunction

  function automatic board_t put_row(input board_t b, input int r, input row_t rw);
    b[r*ROW +: ROW] = rw;
    return b;
  endfunction

  task automatic get_hole(input logic [3:0] hc, output logic [3:0] h_o);
`ifdef GARBAGE_LFSR_EN
    h_o = 4'(lfsr_m % 8'(W));
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    if (hc > 4'd15) h_o = 4'd0;
`else
    h_o = 4'(hc % 4'(W));
`endif
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", board_t'(req_ready), board_t'(1));
    chk("rst_board", board_out, '0);
    chk("rst_done", board_t'(done), '0);
    chk("rst_top", board_t'(top_out), '0);
    rst_n = 1'b1;

    // Two rows into an empty board, hole 3
    board_in = '0; req_count = 3'd2; hole_col = 4'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t1_busy", board_t'(req_ready), '0);
    tick();
    chk("t1_done_e1", board_t'(done), '0);
    tick();
    get_hole(4'd3, h[0]);
    get_hole(4'd3, h[1]);
    exp_b = put_row('0, 1, garb(h[0]));
    exp_b = put_row(exp_b, 0, garb(h[1]));
    chk("t1_done_e2", board_t'(done), board_t'(1));
    chk("t1_board", board_out, exp_b);
    chk("t1_top", board_t'(top_out), '0);
    tick();
    chk("t1_done_off", board_t'(done), '0);
    chk("t1_ready", board_t'(req_ready), board_t'(1));

    // Top row occupied, one row, hole 12 wraps to 2
    board_in = put_row('0, 19, mk_row(10'h155, 3'd2));
    req_count = 3'd1; hole_col = 4'd12; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t2_top_clr", board_t'(top_out), '0);
    tick();
    get_hole(4'd12, h[0]);
    chk("t2_done", board_t'(done), board_t'(1));
    chk("t2_top", board_t'(top_out), board_t'(1));
    chk("t2_board", board_out, put_row('0, 0, garb(h[0])));
    tick();
    chk("t2_top_sticky", board_t'(top_out), board_t'(1));
    chk("t2_ready", board_t'(req_ready), board_t'(1));

    // Four rows, second request mid-operation is ignored
    board_in = put_row('0, 0, mk_row(10'h0F0, 3'd1));
    req_count = 3'd4; hole_col = 4'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t3_top_clr", board_t'(top_out), '0);
    tick();
    req_valid = 1'b1; req_count = 3'd1; hole_col = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("t3_busy", board_t'(req_ready), '0);
    tick();
    chk("t3_done_e3", board_t'(done), '0);
    tick();
    for (int i = 0; i < 4; i++) get_hole(4'd9, h[i]);
    exp_b = put_row('0, 4, mk_row(10'h0F0, 3'd1));
    for (int i = 0; i < 4; i++) exp_b = put_row(exp_b, 3 - i, garb(h[i]));
    chk("t3_done_e4", board_t'(done), board_t'(1));
    chk("t3_board", board_out, exp_b);
    tick();
    chk("t3_done_off", board_t'(done), '0);
    chk("t3_ready", board_t'(req_ready), board_t'(1));
    tick();
    chk("t3_board_hold", board_out, exp_b);
    chk("t3_no_done", board_t'(done), '0);

    // Reset in the second RISE cycle of a three-row insertion
    board_in = put_row('0, 5, mk_row(10'h3FF, 3'd4));
    req_count = 3'd3; hole_col = 4'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lfsr_m = 8'hA5;
    chk("t4_board", board_out, '0);
    chk("t4_done", board_t'(done), '0);
    chk("t4_ready", board_t'(req_ready), board_t'(1));
    chk("t4_top", board_t'(top_out), '0);
    tick();
    chk("t4_no_done", board_t'(done), '0);
    chk("t4_board_hold", board_out, '0);

    // Load a board, then hold invalid counts
    board_in = put_row('0, 7, mk_row(10'h201, 3'd6));
    req_count = 3'd1; hole_col = 4'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    get_hole(4'd0, h[0]);
    exp_b = put_row('0, 8, mk_row(10'h201, 3'd6));
    exp_b = put_row(exp_b, 0, garb(h[0]));
    chk("t5_done", board_t'(done), board_t'(1));
    chk("t5_board", board_out, exp_b);
    tick();
    board_in = '1; req_count = 3'd0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_cnt0_ready", board_t'(req_ready), board_t'(1));
      chk("t5_cnt0_done", board_t'(done), '0);
      chk("t5_cnt0_board", board_out, exp_b);
    end
    req_count = 3'd5;
    tick();
    chk("t5_cnt5_board", board_out, exp_b);
    chk("t5_cnt5_ready", board_t'(req_ready), board_t'(1));
    req_count = 3'd7;
    tick();
    chk("t5_cnt7_board", board_out, exp_b);
    chk("t5_cnt7_done", board_t'(done), '0);
    req_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
